// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops return one cycle after accept, MUL/DIVU/REMU after WIDTH+1.
// A held result (out_ready=0) blocks new requests; a retiring result may overlap the next accept.
module alu_seq #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_zero,
   output logic             flag_neg,
   output logic             flag_carry,
   output logic             flag_ovf,
   output logic             busy
);
   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = SHW + 1;
   localparam logic [WIDTH-1:0] W_AMT    = WIDTH'(WIDTH);
   localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

   localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4,  OP_NOT  = 4'd5,  OP_SLT  = 4'd6,  OP_SLTU = 4'd7;
   localparam logic [3:0] OP_EQ  = 4'd8,  OP_SLL  = 4'd9,  OP_SRL  = 4'd10, OP_SRA  = 4'd11;
   localparam logic [3:0] OP_MUL = 4'd12, OP_DIVU = 4'd13, OP_REMU = 4'd14;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]           cnt;
   logic [3:0]              op_r;
   logic [WIDTH-1:0]        acc, opa, opb;
   logic [WIDTH-1:0]        acc_nx, opa_nx, opb_nx;
   logic [WIDTH:0]          sum, diff, rem_sh;
   logic [WIDTH-1:0]        rem_sub, sra_v, res_d;
   logic signed [WIDTH-1:0] sa, sb;
   logic [SHW-1:0]          sh;
   logic                    big, ge, carry_d, ovf_d;
   logic                    multi, accept, fin, load;

   assign multi  = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
   assign accept = in_valid && in_ready;
   assign fin    = (state == BUSY) && (cnt == CNT_ONE);
   assign load   = (accept && !multi) || fin;
   assign sa     = a;
   assign sb     = b;

   // One iteration step: MUL accumulates a shifted partial product; DIV shifts one dividend
   // bit into the remainder. With a zero divisor every trial succeeds, giving all-ones / a.
   always_comb begin
      rem_sh  = {acc, opa[WIDTH-1]};
      rem_sub = rem_sh[WIDTH-1:0] - opb;
      ge      = (rem_sh >= {1'b0, opb});
      acc_nx  = acc;
      opa_nx  = opa;
      opb_nx  = opb;
      if (op_r == OP_MUL) begin
         acc_nx = opb[0] ? acc + opa : acc;
         opa_nx = opa << 1;
         opb_nx = opb >> 1;
      end else begin
         acc_nx = ge ? rem_sub : rem_sh[WIDTH-1:0];
         opa_nx = {opa[WIDTH-2:0], ge};
      end
   end

   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      diff    = {1'b0, a} - {1'b0, b};
      big     = (b >= W_AMT);
      sh      = b[SHW-1:0];
      sra_v   = sa >>> sh;
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      if (fin) begin
         res_d = (op_r == OP_DIVU) ? opa_nx : acc_nx;
      end else begin
         case (op)
            OP_ADD: begin
               res_d   = sum[WIDTH-1:0];
               carry_d = sum[WIDTH];
               ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
               res_d   = diff[WIDTH-1:0];
               carry_d = diff[WIDTH];
               ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_XOR:  res_d = a ^ b;
            OP_NOT:  res_d = ~a;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
            OP_EQ:   res_d = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_SLL:  res_d = big ? '0 : (a << sh);
            OP_SRL:  res_d = big ? '0 : (a >> sh);
            OP_SRA:  res_d = big ? {WIDTH{a[WIDTH-1]}} : sra_v;
            default: res_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = multi ? BUSY : DONE;
         BUSY: if (cnt == CNT_ONE) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = in_valid ? (multi ? BUSY : DONE) : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         BUSY: busy = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         op_r       <= '0;
         acc        <= '0;
         opa        <= '0;
         opb        <= '0;
         result     <= '0;
         flag_zero  <= 1'b0;
         flag_neg   <= 1'b0;
         flag_carry <= 1'b0;
         flag_ovf   <= 1'b0;
      end else begin
         if (accept && multi) begin
            op_r <= op;
            opa  <= a;
            opb  <= b;
            acc  <= '0;
            cnt  <= CNT_INIT;
         end else if (state == BUSY) begin
            acc <= acc_nx;
            opa <= opa_nx;
            opb <= opb_nx;
            cnt <= cnt - CNT_ONE;
         end
         if (load) begin
            result     <= res_d;
            flag_zero  <= (res_d == '0);
            flag_neg   <= res_d[WIDTH-1];
            flag_carry <= carry_d;
            flag_ovf   <= ovf_d;
         end
      end
   end
endmodule
